// File: rtl/legv8_pkg.sv
// Shared types and constants for the LEGv8 multi-cycle controller.
// Holds FSM states, opcode patterns and mux/ALU encodings.
package legv8_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    EXEC_R   = 4'd3,
    WB_R     = 4'd4,
    MEM_ADDR = 4'd5,
    MEM_RD   = 4'd6,
    WB_MEM   = 4'd7,
    MEM_WR   = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10,
    TRAP     = 4'd11
  } state_t;

  typedef enum logic [2:0] {
    OC_R       = 3'd0,
    OC_LOAD    = 3'd1,
    OC_STORE   = 3'd2,
    OC_CBZ     = 3'd3,
    OC_B       = 3'd4,
    OC_ILLEGAL = 3'd5
  } opclass_t;

  localparam int PC_INC = 4;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  localparam logic [7:0] PFX_CBZ = 8'b10110100;
  localparam logic [5:0] PFX_B   = 6'b000101;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_PASS = 2'b01;
  localparam logic [1:0] ALU_FUNC = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_PCINC = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;

  localparam logic SRCA_PC  = 1'b0;
  localparam logic SRCA_REG = 1'b1;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction/data memory handshake between controller and memories.
// Controller is master (issues requests), memories are slave.
interface multicycle_ctrl_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ready;

  modport master (
    output imem_req, dmem_req, dmem_we,
    input  imem_ready, dmem_ready
  );

  modport slave (
    input  imem_req, dmem_req, dmem_we,
    output imem_ready, dmem_ready
  );
endinterface

// File: rtl/legv8_opclass_decode.sv
// Classifies the 11-bit opcode field into an instruction class.
// Pure combinational; unknown patterns map to OC_ILLEGAL.
module legv8_opclass_decode
  import legv8_pkg::*;
(
  input  logic [10:0] op,
  output opclass_t    oc
);

  // priority-free classification, patterns are disjoint
  always_comb begin
    oc = OC_ILLEGAL;
    unique case (1'b1)
      (op == OP_ADD), (op == OP_SUB),
      (op == OP_AND), (op == OP_ORR):
        oc = OC_R;
      (op == OP_LDUR):       oc = OC_LOAD;
      (op == OP_STUR):       oc = OC_STORE;
      (op[10:3] == PFX_CBZ): oc = OC_CBZ;
      (op[10:5] == PFX_B):   oc = OC_B;
      default:               oc = OC_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle LEGv8 datapath.
// Optional perf counters under MC_PERF_CNT_EN.
module multicycle_ctrl
  import legv8_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [10:0]        Opcode_field,
  multicycle_ctrl_if.master  mem,
  output logic [1:0]         ALU_Op,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               pc_src,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               ir_write,
  output logic               reg_write,
  output logic               mem_to_reg,
  output logic               halted
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0]        cycle_count,
  output logic [31:0]        retired_count
`endif
);

  state_t   state_q;
  state_t   state_d;
  state_t   end_st;
  opclass_t oc;

  legv8_opclass_decode u_dec (
    .op (Opcode_field),
    .oc (oc)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next state; run only matters in IDLE and at instruction end
  always_comb begin
    end_st  = run ? FETCH : IDLE;
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (run) state_d = FETCH;
      FETCH:    if (mem.imem_ready) state_d = DECODE;
      DECODE: begin
        unique case (oc)
          OC_R:             state_d = EXEC_R;
          OC_LOAD,
          OC_STORE:         state_d = MEM_ADDR;
          OC_CBZ:           state_d = BRANCH;
          OC_B:             state_d = JUMP;
          default:          state_d = TRAP;
        endcase
      end
      EXEC_R:   state_d = WB_R;
      MEM_ADDR: state_d = (oc == OC_LOAD) ? MEM_RD : MEM_WR;
      MEM_RD:   if (mem.dmem_ready) state_d = WB_MEM;
      MEM_WR:   if (mem.dmem_ready) state_d = end_st;
      WB_R,
      WB_MEM,
      BRANCH,
      JUMP:     state_d = end_st;
      TRAP:     state_d = TRAP;
      default:  state_d = IDLE;
    endcase
  end

  // Moore output decode; fetch strobes wait for imem_ready
  always_comb begin
    ALU_Op        = ALU_ADD;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_REG;
    pc_src        = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    halted        = 1'b0;
    mem.imem_req  = 1'b0;
    mem.dmem_req  = 1'b0;
    mem.dmem_we   = 1'b0;
    unique case (state_q)
      FETCH: begin
        mem.imem_req = 1'b1;
        alu_src_b    = SRCB_PCINC;
        ir_write     = mem.imem_ready;
        pc_write     = mem.imem_ready;
      end
      EXEC_R: begin
        ALU_Op    = ALU_FUNC;
        alu_src_a = SRCA_REG;
      end
      WB_R: reg_write = 1'b1;
      MEM_ADDR: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
      end
      MEM_RD: mem.dmem_req = 1'b1;
      WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        mem.dmem_req = 1'b1;
        mem.dmem_we  = 1'b1;
      end
      BRANCH: begin
        ALU_Op        = ALU_PASS;
        alu_src_a     = SRCA_REG;
        pc_src        = 1'b1;
        pc_write_cond = 1'b1;
      end
      JUMP: begin
        pc_src   = 1'b1;
        pc_write = 1'b1;
      end
      TRAP: halted = 1'b1;
      default: ;
    endcase
  end

`ifdef MC_PERF_CNT_EN
  logic active;
  logic retire;

  // activity and retirement qualifiers for the counters
  always_comb begin
    active = (state_q != IDLE) && (state_q != TRAP);
    retire = (state_q == WB_R) || (state_q == WB_MEM) ||
             (state_q == BRANCH) || (state_q == JUMP) ||
             ((state_q == MEM_WR) && mem.dmem_ready);
  end

  // free-running wrap-around performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count   <= '0;
      retired_count <= '0;
    end else begin
      if (active) cycle_count   <= cycle_count + 32'd1;
      if (retire) retired_count <= retired_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl.
// Build with +define+MC_PERF_CNT_EN to also check the counters.
module tb_multicycle_ctrl;
  import legv8_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [10:0] opcode;
  logic [1:0]  alu_op;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        pc_src;
  logic        pc_write;
  logic        pc_write_cond;
  logic        ir_write;
  logic        reg_write;
  logic        mem_to_reg;
  logic        halted;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_count;
  logic [31:0] retired_count;
`endif

  multicycle_ctrl_if mem();

  multicycle_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .run           (run),
    .Opcode_field  (opcode),
    .mem           (mem),
    .ALU_Op        (alu_op),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .pc_src        (pc_src),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .mem_to_reg    (mem_to_reg),
    .halted        (halted)
`ifdef MC_PERF_CNT_EN
    ,
    .cycle_count   (cycle_count),
    .retired_count (retired_count)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [10:0] T_ADD  = 11'b10001011000;
  localparam logic [10:0] T_LDUR = 11'b11111000010;
  localparam logic [10:0] T_STUR = 11'b11111000000;
  localparam logic [10:0] T_CBZ  = 11'b10110100101;
  localparam logic [10:0] T_B    = 11'b00010110011;
  localparam logic [10:0] T_BAD  = 11'b11111111111;

  int n_chk = 0;
  int n_fail = 0;

  logic [14:0] outs;
  assign outs = {alu_op, alu_src_a, alu_src_b, pc_src, pc_write,
                 pc_write_cond, ir_write, mem.imem_req, mem.dmem_req,
                 mem.dmem_we, reg_write, mem_to_reg, halted};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // expected output word per state, transcribed by hand
  function automatic logic [14:0] spec_out(state_t s, logic ir);
    logic [14:0] v;
    v = '0;
    case (s)
      FETCH:    v = {2'b00, 1'b0, 2'b01, 1'b0, ir, 1'b0, ir, 1'b1, 5'b0};
      EXEC_R:   v = {2'b10, 1'b1, 2'b00, 10'b0};
      WB_R:     v = {12'b0, 1'b1, 1'b0, 1'b0};
      MEM_ADDR: v = {2'b00, 1'b1, 2'b10, 10'b0};
      MEM_RD:   v = {10'b0, 1'b1, 4'b0};
      WB_MEM:   v = {12'b0, 1'b1, 1'b1, 1'b0};
      MEM_WR:   v = {10'b0, 1'b1, 1'b1, 3'b0};
      BRANCH:   v = {2'b01, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 7'b0};
      JUMP:     v = {5'b0, 1'b1, 1'b1, 8'b0};
      TRAP:     v = {14'b0, 1'b1};
      default:  v = '0;
    endcase
    return v;
  endfunction

  task automatic cyc(input string tag, input state_t st,
                     input logic [10:0] op, input logic ir,
                     input logic dr, input logic rn);
    opcode = op;
    mem.imem_ready = ir;
    mem.dmem_ready = dr;
    run = rn;
    #1;
    chk({tag, "/st"}, 32'(dut.state_q), 32'(st));
    chk({tag, "/out"}, 32'(outs), 32'(spec_out(st, ir)));
    chk({tag, "/excl"},
        32'({pc_write & pc_write_cond, reg_write & mem.dmem_req}), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run = 1'b0;
    mem.imem_ready = 1'b0;
    mem.dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    opcode = '0;
    do_reset();
    chk("rst/st", 32'(dut.state_q), 32'(IDLE));
    chk("rst/out", 32'(outs), 32'd0);
`ifdef MC_PERF_CNT_EN
    chk("rst/cyc", cycle_count, 32'd0);
    chk("rst/ret", retired_count, 32'd0);
`endif

    // 1: ADD, zero-wait
    cyc("add", IDLE,   T_ADD, 1, 0, 1);
    cyc("add", FETCH,  T_ADD, 1, 0, 1);
    cyc("add", DECODE, T_ADD, 1, 0, 1);
    cyc("add", EXEC_R, T_ADD, 1, 0, 1);
    cyc("add", WB_R,   T_ADD, 1, 0, 0);
    cyc("add", IDLE,   T_ADD, 1, 0, 0);

    // 2: LDUR with 3 data wait cycles
    cyc("ld", IDLE,     T_LDUR, 1, 0, 1);
    cyc("ld", FETCH,    T_LDUR, 1, 0, 1);
    cyc("ld", DECODE,   T_LDUR, 1, 0, 1);
    cyc("ld", MEM_ADDR, T_LDUR, 1, 0, 1);
    for (int i = 0; i < 3; i++) cyc("ld_w", MEM_RD, T_LDUR, 1, 0, 1);
    cyc("ld", MEM_RD,   T_LDUR, 1, 1, 1);
    cyc("ld", WB_MEM,   T_LDUR, 1, 0, 0);
    cyc("ld", IDLE,     T_LDUR, 1, 0, 0);

    // 3: STUR (with fetch and data wait) then CBZ
    cyc("st", IDLE,     T_STUR, 0, 0, 1);
    cyc("st", FETCH,    T_STUR, 0, 0, 1);
    cyc("st", FETCH,    T_STUR, 1, 0, 1);
    cyc("st", DECODE,   T_STUR, 1, 0, 1);
    cyc("st", MEM_ADDR, T_STUR, 1, 0, 1);
    cyc("st", MEM_WR,   T_STUR, 1, 0, 1);
    cyc("st", MEM_WR,   T_STUR, 1, 1, 1);
    cyc("cbz", FETCH,   T_CBZ,  1, 0, 1);
    cyc("cbz", DECODE,  T_CBZ,  1, 0, 1);
    cyc("cbz", BRANCH,  T_CBZ,  1, 0, 0);
    cyc("cbz", IDLE,    T_CBZ,  1, 0, 0);

    // 4: illegal opcode traps until reset
    cyc("bad", IDLE,   T_BAD, 1, 0, 1);
    cyc("bad", FETCH,  T_BAD, 1, 0, 1);
    cyc("bad", DECODE, T_BAD, 1, 0, 1);
    for (int i = 0; i < 20; i++) cyc("trap", TRAP, T_BAD, 1, 0, i[0]);
    rst_n = 1'b0;
    #1;
    chk("trap_rst/st", 32'(dut.state_q), 32'(IDLE));
    chk("trap_rst/halt", 32'(halted), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 5: reset during MEM_RD
    cyc("rrd", IDLE,     T_LDUR, 1, 0, 1);
    cyc("rrd", FETCH,    T_LDUR, 1, 0, 1);
    cyc("rrd", DECODE,   T_LDUR, 1, 0, 1);
    cyc("rrd", MEM_ADDR, T_LDUR, 1, 0, 1);
    opcode = T_LDUR;
    mem.dmem_ready = 1'b0;
    #1;
    chk("rrd/pre", 32'(dut.state_q), 32'(MEM_RD));
    rst_n = 1'b0;
    #1;
    chk("rrd/st", 32'(dut.state_q), 32'(IDLE));
    chk("rrd/dreq", 32'(mem.dmem_req), 32'd0);
    chk("rrd/out", 32'(outs), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc("rrd_post", IDLE, T_LDUR, 1, 1, 0);

    // 6: B then ADD, zero-wait
    do_reset();
    cyc("b", IDLE,      T_B,   1, 0, 1);
    cyc("b", FETCH,     T_B,   1, 0, 1);
    cyc("b", DECODE,    T_B,   1, 0, 1);
    cyc("b", JUMP,      T_B,   1, 0, 1);
    cyc("b2", FETCH,    T_ADD, 1, 0, 1);
    cyc("b2", DECODE,   T_ADD, 1, 0, 1);
    cyc("b2", EXEC_R,   T_ADD, 1, 0, 1);
    cyc("b2", WB_R,     T_ADD, 1, 0, 0);
    cyc("b2", IDLE,     T_ADD, 1, 0, 0);
`ifdef MC_PERF_CNT_EN
    chk("perf/cyc", cycle_count, 32'd7);
    chk("perf/ret", retired_count, 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
